// File: rtl/panda_pkg.sv
// Shared types for the Panda core: LSU access widths, LSU FSM states and
// the control tag that travels down the LSU read pipeline.
package panda_pkg;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_width_e;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_SECOND = 1'b1
    } lsu_state_e;

    // fin=0 marks the first half of a split access; merge=1 marks its second half
    typedef struct packed {
        logic       vld;
        logic       fin;
        logic       err;
        logic       ld;
        logic       merge;
        lsu_width_e width;
        logic       uns;
        logic [1:0] off;
    } lsu_tag_t;

    function automatic logic [3:0] lsu_base_be(lsu_width_e w);
        case (w)
            LSU_BYTE: return 4'b0001;
            LSU_HALF: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/panda_lsu_mem_if.sv
// Core-side request/response bundle of the load-store unit.
interface panda_lsu_mem_if;
    import panda_pkg::*;

    logic        req_i;
    logic        we_i;
    lsu_width_e  width_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] rdata_o;

    modport slave (
        input  req_i, we_i, width_i, unsigned_i, addr_i, wdata_i,
        output busy_o, done_o, err_o, rdata_o
    );

    modport master (
        output req_i, we_i, width_i, unsigned_i, addr_i, wdata_i,
        input  busy_o, done_o, err_o, rdata_o
    );

endinterface

// File: rtl/panda_ram.sv
// Single-port byte-writable RAM with synchronous read and an optional
// output register (read latency 1 + OutputReg).
module panda_ram #(
    parameter int    DataWidth = 32,
    parameter int    Depth     = 1024,
    parameter bit    OutputReg = 1'b1,
    parameter string InitFile  = ""
) (
    input  logic                     clk_i,
    input  logic                     ce_i,
    input  logic [DataWidth/8-1:0]   we_i,
    input  logic [$clog2(Depth)-1:0] addr_i,
    input  logic [DataWidth-1:0]     wdata_i,
    output logic [DataWidth-1:0]     rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rd_d, rd_q;

    // Preloading from InitFile is done by the memory-initialisation step of the build.
    logic init_file_unused;
    assign init_file_unused = (InitFile != "");

    always_comb rd_d = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            for (int i = 0; i < DataWidth / 8; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
            rd_q <= rd_d;
        end
    end

    if (OutputReg) begin : g_oreg
        logic [DataWidth-1:0] out_d, out_q;
        always_comb out_d = rd_q;
        always_ff @(posedge clk_i) begin
            if (ce_i) out_q <= out_d;
        end
        assign rdata_o = out_q;
    end else begin : g_noreg
        assign rdata_o = rd_q;
    end

endmodule

// File: rtl/panda_lsu_mem.sv
// Load-store unit plus data memory: byte/half/word access with configurable
// RAM latency, misaligned splitting into two word accesses, and range errors.
module panda_lsu_mem
    import panda_pkg::*;
#(
    parameter int unsigned DataMemDepth    = 1024,
    parameter string       DataMemInitFile = "",
    parameter bit          OutputReg       = 1'b1,
    parameter bit          MisalignedEn    = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    panda_lsu_mem_if.slave  bus
);

    localparam int AW = $clog2(DataMemDepth);

    function automatic logic [31:0] rotl_bytes(logic [31:0] d, logic [1:0] off);
        logic [63:0] t;
        t = {d, d} << {off, 3'b000};
        return t[63:32];
    endfunction

    function automatic logic [31:0] load_extend(logic [31:0] d, lsu_width_e w, logic uns);
        case (w)
            LSU_BYTE: return {{24{~uns & d[7]}}, d[7:0]};
            LSU_HALF: return {{16{~uns & d[15]}}, d[15:0]};
            default:  return d;
        endcase
    endfunction

    lsu_state_e    state_q, state_d;
    lsu_tag_t      tag_in, tag_p0_d, tag_p0_q, tag_out;
    lsu_tag_t      sec_tag_d, sec_tag_q;
    logic [AW-1:0] sec_word_d, sec_word_q;
    logic [3:0]    sec_be_d, sec_be_q;
    logic [31:0]   sec_wdata_d, sec_wdata_q;
    logic [31:0]   hold_d, hold_q;

    logic [AW-1:0] word, ram_addr;
    logic [1:0]    off;
    logic [7:0]    be8;
    logic [3:0]    ram_be;
    logic [31:0]   wrot, ram_wdata, ram_rdata, sel;
    logic [63:0]   data64;
    logic          oor, mis, split, acc_err, done;

    assign word    = bus.addr_i[AW+1:2];
    assign off     = bus.addr_i[1:0];
    assign oor     = |bus.addr_i[31:AW+2];
    // Lanes that spill past byte 3 are exactly the misaligned cases.
    assign be8     = {4'b0000, lsu_base_be(bus.width_i)} << off;
    assign mis     = |be8[7:4];
    assign acc_err = oor || (mis && !MisalignedEn);
    assign split   = mis && MisalignedEn && !oor;
    assign wrot    = rotl_bytes(bus.wdata_i, off);

    always_comb begin
        state_d     = state_q;
        tag_in      = '0;
        ram_addr    = word;
        ram_be      = '0;
        ram_wdata   = wrot;
        sec_tag_d   = sec_tag_q;
        sec_word_d  = sec_word_q;
        sec_be_d    = sec_be_q;
        sec_wdata_d = sec_wdata_q;
        case (state_q)
            LSU_IDLE: begin
                if (bus.req_i) begin
                    tag_in.vld   = 1'b1;
                    tag_in.fin   = !split;
                    tag_in.err   = acc_err;
                    tag_in.ld    = !bus.we_i;
                    tag_in.width = bus.width_i;
                    tag_in.uns   = bus.unsigned_i;
                    tag_in.off   = off;
                    if (!acc_err && bus.we_i) ram_be = be8[3:0];
                    if (split) begin
                        state_d         = LSU_SECOND;
                        sec_tag_d       = tag_in;
                        sec_tag_d.fin   = 1'b1;
                        sec_tag_d.merge = 1'b1;
                        sec_word_d      = word + AW'(1);
                        sec_be_d        = bus.we_i ? be8[7:4] : 4'b0000;
                        sec_wdata_d     = wrot;
                    end
                end
            end
            LSU_SECOND: begin
                state_d   = LSU_IDLE;
                tag_in    = sec_tag_q;
                ram_addr  = sec_word_q;
                ram_be    = sec_be_q;
                ram_wdata = sec_wdata_q;
            end
        endcase
    end

    panda_ram #(
        .DataWidth (32),
        .Depth     (DataMemDepth),
        .OutputReg (OutputReg),
        .InitFile  (DataMemInitFile)
    ) u_ram (
        .clk_i   (clk_i),
        .ce_i    (!rst_i),
        .we_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Stage p0: RAM address registered, tag follows
    always_comb tag_p0_d = tag_in;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LSU_IDLE;
            tag_p0_q <= '0;
        end else begin
            state_q  <= state_d;
            tag_p0_q <= tag_p0_d;
        end
    end

    always_ff @(posedge clk_i) begin
        sec_tag_q   <= sec_tag_d;
        sec_word_q  <= sec_word_d;
        sec_be_q    <= sec_be_d;
        sec_wdata_q <= sec_wdata_d;
        hold_q      <= hold_d;
    end

    // Stage p1: tag aligned with the RAM output register
    if (OutputReg) begin : g_p1
        lsu_tag_t tag_p1_d, tag_p1_q;
        always_comb tag_p1_d = tag_p0_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) tag_p1_q <= '0;
            else       tag_p1_q <= tag_p1_d;
        end
        assign tag_out = tag_p1_q;
    end else begin : g_p0
        assign tag_out = tag_p0_q;
    end

    assign done   = tag_out.vld && tag_out.fin;
    assign hold_d = (tag_out.vld && !tag_out.fin) ? ram_rdata : hold_q;
    assign data64 = tag_out.merge ? {ram_rdata, hold_q} : {32'h0, ram_rdata};
    assign sel    = 32'(data64 >> {tag_out.off, 3'b000});

    assign bus.busy_o  = (state_q == LSU_SECOND);
    assign bus.done_o  = done;
    assign bus.err_o   = done && tag_out.err;
    assign bus.rdata_o = (done && tag_out.ld && !tag_out.err) ?
                         load_extend(sel, tag_out.width, tag_out.uns) : 32'h0;

endmodule

// File: tb/tb_panda_lsu_mem.sv
// Directed bench for panda_lsu_mem: dut_a (Depth 32, L=2, split on) and
// dut_b (Depth 32, L=1, misaligned flagged as error).
module tb_panda_lsu_mem;
    import panda_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    int          lat, bc;
    logic        er, da;
    logic [31:0] rd;

    panda_lsu_mem_if bus_a();
    panda_lsu_mem_if bus_b();

    panda_lsu_mem #(
        .DataMemDepth(32), .DataMemInitFile(""), .OutputReg(1'b1), .MisalignedEn(1'b1)
    ) dut_a (.clk_i(clk), .rst_i(rst), .bus(bus_a));

    panda_lsu_mem #(
        .DataMemDepth(32), .DataMemInitFile(""), .OutputReg(1'b0), .MisalignedEn(1'b0)
    ) dut_b (.clk_i(clk), .rst_i(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic drive(input bit b, input logic req, input logic we, input lsu_width_e w,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        if (b) begin
            bus_b.req_i = req; bus_b.we_i = we; bus_b.width_i = w;
            bus_b.unsigned_i = uns; bus_b.addr_i = addr; bus_b.wdata_i = wd;
        end else begin
            bus_a.req_i = req; bus_a.we_i = we; bus_a.width_i = w;
            bus_a.unsigned_i = uns; bus_a.addr_i = addr; bus_a.wdata_i = wd;
        end
    endtask

    function automatic logic get_done(input bit b);
        return b ? bus_b.done_o : bus_a.done_o;
    endfunction

    // One access; leaves latency (-1 on timeout), busy count, err, rdata and the
    // done level one cycle after the pulse in lat/bc/er/rd/da.
    task automatic access(input bit b, input logic we, input lsu_width_e w, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        drive(b, 1'b1, we, w, uns, addr, wd);
        lat = -1; bc = 0; er = 1'b0; rd = 32'h0; da = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) drive(b, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
            if (b ? bus_b.busy_o : bus_a.busy_o) bc++;
            if (get_done(b)) begin
                lat = i;
                er  = b ? bus_b.err_o : bus_a.err_o;
                rd  = b ? bus_b.rdata_o : bus_a.rdata_o;
                break;
            end
        end
        @(negedge clk);
        da = get_done(b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus_a.busy_o !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", bus_a.busy_o); else passed++;
        total++; if (bus_a.done_o !== 1'b0) $display("FAIL reset_done_a: got %b want 0", bus_a.done_o); else passed++;
        total++; if (bus_a.err_o !== 1'b0) $display("FAIL reset_err_a: got %b want 0", bus_a.err_o); else passed++;
        total++; if (bus_a.rdata_o !== 32'h0) $display("FAIL reset_rdata_a: got %h want 0", bus_a.rdata_o); else passed++;
        total++; if (bus_b.busy_o !== 1'b0) $display("FAIL reset_busy_b: got %b want 0", bus_b.busy_o); else passed++;
        total++; if (bus_b.done_o !== 1'b0) $display("FAIL reset_done_b: got %b want 0", bus_b.done_o); else passed++;
        total++; if (bus_b.rdata_o !== 32'h0) $display("FAIL reset_rdata_b: got %h want 0", bus_b.rdata_o); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_word_aligned();
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        total++; if (lat !== 2) $display("FAIL st_word_lat: got %0d want 2", lat); else passed++;
        total++; if (er !== 1'b0) $display("FAIL st_word_err: got %b want 0", er); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL st_word_rdata: got %h want 0", rd); else passed++;
        total++; if (bc !== 0) $display("FAIL st_word_busy: got %0d want 0", bc); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h10, 32'h0);
        total++; if (lat !== 2) $display("FAIL ld_word_lat: got %0d want 2", lat); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_word_rdata: got %h want deadbeef", rd); else passed++;
        total++; if (er !== 1'b0) $display("FAIL ld_word_err: got %b want 0", er); else passed++;
        total++; if (da !== 1'b0) $display("FAIL ld_word_pulse: got %b want 0", da); else passed++;
    endtask

    task automatic test_load_extend();
        access(0, 1'b0, LSU_BYTE, 1'b0, 32'h13, 32'h0);
        total++; if (rd !== 32'hFFFFFFDE) $display("FAIL ld_byte_s: got %h want ffffffde", rd); else passed++;
        access(0, 1'b0, LSU_BYTE, 1'b1, 32'h13, 32'h0);
        total++; if (rd !== 32'h000000DE) $display("FAIL ld_byte_u: got %h want 000000de", rd); else passed++;
        access(0, 1'b0, LSU_HALF, 1'b0, 32'h11, 32'h0);
        total++; if (rd !== 32'hFFFFADBE) $display("FAIL ld_half_off1: got %h want ffffadbe", rd); else passed++;
        total++; if (lat !== 2) $display("FAIL ld_half_off1_lat: got %0d want 2", lat); else passed++;
        access(0, 1'b0, LSU_HALF, 1'b1, 32'h12, 32'h0);
        total++; if (rd !== 32'h0000DEAD) $display("FAIL ld_half_u: got %h want 0000dead", rd); else passed++;
    endtask

    task automatic test_misaligned();
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h20, 32'h0);
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h24, 32'h0);
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h21, 32'h11223344);
        total++; if (lat !== 3) $display("FAIL mis_st_lat: got %0d want 3", lat); else passed++;
        total++; if (bc !== 1) $display("FAIL mis_st_busy: got %0d want 1", bc); else passed++;
        total++; if (er !== 1'b0) $display("FAIL mis_st_err: got %b want 0", er); else passed++;
        total++; if (da !== 1'b0) $display("FAIL mis_st_pulse: got %b want 0", da); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h21, 32'h0);
        total++; if (lat !== 3) $display("FAIL mis_ld_lat: got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'h11223344) $display("FAIL mis_ld_rdata: got %h want 11223344", rd); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h20, 32'h0);
        total++; if (rd !== 32'h22334400) $display("FAIL mis_word8: got %h want 22334400", rd); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h24, 32'h0);
        total++; if (rd !== 32'h00000011) $display("FAIL mis_word9: got %h want 00000011", rd); else passed++;
    endtask

    task automatic test_wrap();
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h7C, 32'h0);
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h00, 32'h0);
        access(0, 1'b1, LSU_HALF, 1'b0, 32'h7F, 32'h0000A55A);
        total++; if (lat !== 3) $display("FAIL wrap_st_lat: got %0d want 3", lat); else passed++;
        total++; if (bc !== 1) $display("FAIL wrap_st_busy: got %0d want 1", bc); else passed++;
        access(0, 1'b0, LSU_HALF, 1'b1, 32'h7F, 32'h0);
        total++; if (rd !== 32'h0000A55A) $display("FAIL wrap_ld_half_u: got %h want 0000a55a", rd); else passed++;
        access(0, 1'b0, LSU_HALF, 1'b0, 32'h7F, 32'h0);
        total++; if (rd !== 32'hFFFFA55A) $display("FAIL wrap_ld_half_s: got %h want ffffa55a", rd); else passed++;
        access(0, 1'b0, LSU_BYTE, 1'b1, 32'h7F, 32'h0);
        total++; if (rd !== 32'h0000005A) $display("FAIL wrap_byte_7f: got %h want 0000005a", rd); else passed++;
        access(0, 1'b0, LSU_BYTE, 1'b1, 32'h00, 32'h0);
        total++; if (rd !== 32'h000000A5) $display("FAIL wrap_byte_00: got %h want 000000a5", rd); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h7C, 32'h0);
        total++; if (rd !== 32'h5A000000) $display("FAIL wrap_word_7c: got %h want 5a000000", rd); else passed++;
    endtask

    task automatic test_out_of_range();
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h80, 32'h0);
        total++; if (lat !== 2) $display("FAIL oor_ld_lat: got %0d want 2", lat); else passed++;
        total++; if (er !== 1'b1) $display("FAIL oor_ld_err: got %b want 1", er); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL oor_ld_rdata: got %h want 0", rd); else passed++;
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h80, 32'hFFFFFFFF);
        total++; if (er !== 1'b1) $display("FAIL oor_st_err: got %b want 1", er); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h00, 32'h0);
        total++; if (rd !== 32'h000000A5) $display("FAIL oor_mem_kept: got %h want 000000a5", rd); else passed++;
        total++; if (er !== 1'b0) $display("FAIL oor_inrange_err: got %b want 0", er); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h81, 32'h0);
        total++; if (lat !== 2) $display("FAIL oor_mis_lat: got %0d want 2", lat); else passed++;
        total++; if (er !== 1'b1 || bc !== 0) $display("FAIL oor_mis_err: got err %b busy %0d want 1/0", er, bc); else passed++;
    endtask

    task automatic test_misaligned_disabled();
        access(1, 1'b1, LSU_WORD, 1'b0, 32'h04, 32'hA5A5A5A5);
        access(1, 1'b1, LSU_WORD, 1'b0, 32'h08, 32'h12345678);
        total++; if (lat !== 1) $display("FAIL b_st_lat: got %0d want 1", lat); else passed++;
        access(1, 1'b0, LSU_WORD, 1'b0, 32'h08, 32'h0);
        total++; if (lat !== 1) $display("FAIL b_ld_lat: got %0d want 1", lat); else passed++;
        total++; if (rd !== 32'h12345678) $display("FAIL b_ld_rdata: got %h want 12345678", rd); else passed++;
        access(1, 1'b0, LSU_HALF, 1'b1, 32'h09, 32'h0);
        total++; if (rd !== 32'h00003456 || er !== 1'b0) $display("FAIL b_half_off1: got %h err %b want 00003456/0", rd, er); else passed++;
        access(1, 1'b0, LSU_WORD, 1'b0, 32'h02, 32'h0);
        total++; if (lat !== 1) $display("FAIL b_mis_lat: got %0d want 1", lat); else passed++;
        total++; if (er !== 1'b1) $display("FAIL b_mis_err: got %b want 1", er); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL b_mis_rdata: got %h want 0", rd); else passed++;
        access(1, 1'b1, LSU_HALF, 1'b0, 32'h07, 32'h0000FFFF);
        total++; if (er !== 1'b1 || bc !== 0) $display("FAIL b_mis_st: got err %b busy %0d want 1/0", er, bc); else passed++;
        access(1, 1'b0, LSU_WORD, 1'b0, 32'h04, 32'h0);
        total++; if (rd !== 32'hA5A5A5A5) $display("FAIL b_mis_st_word1: got %h want a5a5a5a5", rd); else passed++;
        access(1, 1'b0, LSU_WORD, 1'b0, 32'h08, 32'h0);
        total++; if (rd !== 32'h12345678) $display("FAIL b_mis_st_word2: got %h want 12345678", rd); else passed++;
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h40, 32'h0);
        access(0, 1'b1, LSU_WORD, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, LSU_WORD, 1'b0, 32'h42, 32'hCAFEF00D);
        @(negedge clk);
        total++; if (bus_a.busy_o !== 1'b1) $display("FAIL rmid_busy_second: got %b want 1", bus_a.busy_o); else passed++;
        drive(0, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus_a.busy_o !== 1'b0) $display("FAIL rmid_busy_after: got %b want 0", bus_a.busy_o); else passed++;
        saw_done = bus_a.done_o;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus_a.done_o) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL rmid_done: got %b want 0", saw_done); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h40, 32'h0);
        total++; if (rd !== 32'hF00D0000) $display("FAIL rmid_first_half: got %h want f00d0000", rd); else passed++;
        access(0, 1'b0, LSU_WORD, 1'b0, 32'h44, 32'h0);
        total++; if (rd !== 32'h0) $display("FAIL rmid_second_half: got %h want 0", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(0, 1'b1, 1'b0, LSU_WORD, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, LSU_WORD, 1'b0, 32'h20, 32'h0);
        total++; if (bus_a.busy_o !== 1'b0) $display("FAIL b2b_busy1: got %b want 0", bus_a.busy_o); else passed++;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, LSU_WORD, 1'b0, 32'h24, 32'h0);
        total++; if (bus_a.done_o !== 1'b1 || bus_a.rdata_o !== 32'hDEADBEEF) $display("FAIL b2b_a0: got %b/%h want 1/deadbeef", bus_a.done_o, bus_a.rdata_o); else passed++;
        @(negedge clk);
        drive(0, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
        total++; if (bus_a.done_o !== 1'b1 || bus_a.rdata_o !== 32'h22334400) $display("FAIL b2b_a1: got %b/%h want 1/22334400", bus_a.done_o, bus_a.rdata_o); else passed++;
        @(negedge clk);
        total++; if (bus_a.done_o !== 1'b1 || bus_a.rdata_o !== 32'h00000011) $display("FAIL b2b_a2: got %b/%h want 1/00000011", bus_a.done_o, bus_a.rdata_o); else passed++;
        @(negedge clk);
        total++; if (bus_a.done_o !== 1'b0) $display("FAIL b2b_a_end: got %b want 0", bus_a.done_o); else passed++;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, LSU_WORD, 1'b0, 32'h08, 32'h0);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, LSU_WORD, 1'b0, 32'h04, 32'h0);
        total++; if (bus_b.done_o !== 1'b1 || bus_b.rdata_o !== 32'h12345678) $display("FAIL b2b_b0: got %b/%h want 1/12345678", bus_b.done_o, bus_b.rdata_o); else passed++;
        @(negedge clk);
        drive(1, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
        total++; if (bus_b.done_o !== 1'b1 || bus_b.rdata_o !== 32'hA5A5A5A5) $display("FAIL b2b_b1: got %b/%h want 1/a5a5a5a5", bus_b.done_o, bus_b.rdata_o); else passed++;
        @(negedge clk);
        total++; if (bus_b.done_o !== 1'b0) $display("FAIL b2b_b_end: got %b want 0", bus_b.done_o); else passed++;
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0);
        test_reset();
        test_word_aligned();
        test_load_extend();
        test_misaligned();
        test_wrap();
        test_out_of_range();
        test_misaligned_disabled();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
